lc3_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the LC-3 control unit.
- Owns the PC register and applies control-unit PC updates (pc_write/pc_sel), using either a sign-extended offset or a register target.
- Fetches the instruction word from instruction memory over a ready-based handshake and presents it, held stable, as instr/instr_valid.
- Supplies pc_plus1 for the JSR/JSRR R7 link and an optional fetch timeout that substitutes TRAP HALT.

---
 rtl/lc3_fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_lc3_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_fetch_unit.sv
// ---------------------------------------------------------------------------
// lc3_fetch_unit
//   Instruction-fetch stage in front of the LC-3 control unit. It owns the
//   PC, applies PC updates from the control unit, fetches one instruction
//   word per accepted fetch_req over a ready-based memory handshake, and
//   holds the fetched word stable on instr/instr_valid.
//
//   Optional build macro: FETCH_TIMEOUT_EN
//     When defined, a fetch that waits MAX_WAIT cycles in WAIT without
//     mem_ready completes with TRAP x25 (HALT) and sets sticky fetch_err.
//     When undefined, WAIT lasts until mem_ready and fetch_err is 0.
//
//   Parameters:
//     RESET_PC  PC value loaded on reset
//     MAX_WAIT  WAIT cycles before timeout (1..255)
//
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     pc_write, pc_sel        PC update strobe and source select
//                             (00 PC+1, 01 PC+1+pc_offset, 10 reg_target,
//                             11 hold)
//     pc_offset, reg_target   sign-extended offset / register target
//     fetch_req               single-cycle request for the next instruction
//     mem_addr, mem_rd        registered memory address and read strobe
//     mem_rdata, mem_ready    memory read data and its valid strobe
//     instr, instr_valid      last fetched word and its valid flag
//     pc, pc_plus1            current PC and PC+1 (link value for JSR/JSRR)
//     busy                    high while a fetch is in flight
//     fetch_err               sticky timeout flag
// ---------------------------------------------------------------------------
module lc3_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] pc_offset,
    input  logic [15:0] reg_target,
    input  logic        fetch_req,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [15:0] TRAP_HALT = 16'hF025;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // Out-of-range MAX_WAIT would make the timeout compare meaningless.
    if ((MAX_WAIT < 32'd1) || (MAX_WAIT > 32'd255)) begin : g_max_wait_range
        $error("lc3_fetch_unit: MAX_WAIT must be in 1..255");
    end

    // PC update rule; all arithmetic wraps modulo 2^16.
    function automatic logic [15:0] pc_update(input logic [1:0]  sel,
                                              input logic [15:0] cur,
                                              input logic [15:0] off,
                                              input logic [15:0] tgt);
        logic [15:0] res;
        case (sel)
            2'b00:   res = cur + 16'd1;
            2'b01:   res = cur + 16'd1 + off;
            2'b10:   res = tgt;
            2'b11:   res = cur;
            default: res = cur;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] pc_r;
    logic [15:0] pc_fwd_s;
    logic [15:0] mem_addr_r;
    logic [15:0] instr_r;
    logic        instr_valid_r;
    logic        busy_r;
    logic        latch_addr_s;
    logic        accept_s;
    logic        timeout_s;
    logic        timeout_hit_s;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 32'd1);

    logic [7:0] wait_cnt_r;
    logic       fetch_err_r;

    assign timeout_hit_s = (wait_cnt_r == WAIT_LAST);
    assign fetch_err     = fetch_err_r;

    // Count consecutive WAIT cycles; restarts at 0 on every entry to WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_err_r <= 1'b0;
        end else if (timeout_s) begin
            fetch_err_r <= 1'b1;
        end else begin
            fetch_err_r <= fetch_err_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign fetch_err     = 1'b0;
`endif

    // Next-state decode and per-cycle fetch events.
    always_comb begin
        state_nxt_s  = state_r;
        latch_addr_s = 1'b0;
        accept_s     = 1'b0;
        timeout_s    = 1'b0;
        // fetch_req forwards a same-cycle PC update into the fetch address
        if (pc_write) begin
            pc_fwd_s = pc_update(pc_sel, pc_r, pc_offset, reg_target);
        end else begin
            pc_fwd_s = pc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (fetch_req) begin
                    state_nxt_s  = ST_REQ;
                    latch_addr_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // ready already in REQ gives the one-cycle best case
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // data wins over a timeout in the same cycle
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                    accept_s    = 1'b1;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, address, strobe and instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            mem_addr_r    <= 16'h0000;
            instr_r       <= 16'h0000;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_fwd_s;
            // busy doubles as the read strobe: both are high in REQ and WAIT
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (latch_addr_s) begin
                mem_addr_r    <= pc_fwd_s;
                instr_valid_r <= 1'b0;
            end else if (accept_s) begin
                instr_r       <= mem_rdata;
                instr_valid_r <= 1'b1;
            end else if (timeout_s) begin
                instr_r       <= TRAP_HALT;
                instr_valid_r <= 1'b1;
            end else begin
                mem_addr_r    <= mem_addr_r;
                instr_r       <= instr_r;
                instr_valid_r <= instr_valid_r;
            end
        end
    end

    assign pc          = pc_r;
    assign pc_plus1    = pc_r + 16'd1;
    assign mem_addr    = mem_addr_r;
    assign mem_rd      = busy_r;
    assign busy        = busy_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_lc3_fetch_unit
//   Self-checking bench for lc3_fetch_unit. A transaction-level reference
//   model (PC value, in-flight flag, edge count since request) predicts every
//   output after each clock; directed scenarios add checks against fixed
//   constants, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_lc3_fetch_unit;

    localparam int MW = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic [15:0] pc_offset;
    logic [15:0] reg_target;
    logic        fetch_req;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        busy;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    logic [15:0] m_instr;
    bit          m_valid;
    bit          m_busy;
    bit          m_err;
    int          m_edges;

    lc3_fetch_unit #(.RESET_PC(16'h3000), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .pc_offset  (pc_offset),
        .reg_target (reg_target),
        .fetch_req  (fetch_req),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [15:0] newpc;
        if (reset) begin
            m_pc = 16'h3000; m_addr = 16'h0000; m_instr = 16'h0000;
            m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_edges = 0;
        end else begin
            newpc = m_pc;
            if (pc_write) begin
                if (pc_sel == 2'd0)      newpc = 16'(m_pc + 1);
                else if (pc_sel == 2'd1) newpc = 16'(m_pc + 1 + pc_offset);
                else if (pc_sel == 2'd2) newpc = reg_target;
            end
            if (m_busy) begin
                m_edges++;
                if (mem_ready) begin
                    m_instr = mem_rdata; m_valid = 1'b1; m_busy = 1'b0;
                end else if (TO_EN && (m_edges == MW + 1)) begin
                    m_instr = 16'hF025; m_valid = 1'b1; m_busy = 1'b0; m_err = 1'b1;
                end
            end else if (fetch_req) begin
                m_busy = 1'b1; m_edges = 0; m_addr = newpc; m_valid = 1'b0;
            end
            m_pc = newpc;
        end
    endtask

    task automatic check_all();
        check_val("pc",          pc,          m_pc);
        check_val("pc_plus1",    pc_plus1,    16'(m_pc + 1));
        check_val("mem_addr",    mem_addr,    m_addr);
        check_val("mem_rd",      16'(mem_rd), 16'(m_busy));
        check_val("busy",        16'(busy),   16'(m_busy));
        check_val("instr",       instr,       m_instr);
        check_val("instr_valid", 16'(instr_valid), 16'(m_valid));
        check_val("fetch_err",   16'(fetch_err),   16'(m_err));
    endtask

    task automatic step(input bit rst, input bit fr, input bit pw, input logic [1:0] sel,
                        input logic [15:0] off, input logic [15:0] tgt,
                        input bit rdy, input logic [15:0] rd);
        reset = rst; fetch_req = fr; pc_write = pw; pc_sel = sel;
        pc_offset = off; reg_target = tgt; mem_ready = rdy; mem_rdata = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic set_pc(input logic [15:0] v);
        step(1'b0, 1'b0, 1'b1, 2'b10, 16'h0000, v, 1'b0, 16'h0000);
    endtask

    task automatic fetch_start();
        step(1'b0, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic wait_edge(input bit rdy, input logic [15:0] rd);
        step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, rdy, rd);
    endtask

    initial begin
        // reset state
        step(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check_val("rst_pc", pc, 16'h3000);
        check_val("rst_valid", 16'(instr_valid), 16'h0000);
        idle(1);

        // basic fetch, ready on first WAIT cycle
        fetch_start();
        wait_edge(1'b0, 16'h0000);
        wait_edge(1'b1, 16'h1221);
        check_val("t1_addr", mem_addr, 16'h3000);
        check_val("t1_instr", instr, 16'h1221);
        check_val("t1_valid", 16'(instr_valid), 16'h0001);
        check_val("t1_pc", pc, 16'h3000);

        // best case: ready already in REQ
        fetch_start();
        wait_edge(1'b1, 16'h5A5A);
        check_val("fast_instr", instr, 16'h5A5A);

        // PC update selects
        set_pc(16'h3005);
        step(1'b0, 1'b0, 1'b1, 2'b01, 16'hFFFC, 16'h0000, 1'b0, 16'h0000);
        check_val("sel01", pc, 16'h3002);
        step(1'b0, 1'b0, 1'b1, 2'b10, 16'h0000, 16'h4000, 1'b0, 16'h0000);
        check_val("sel10", pc, 16'h4000);
        step(1'b0, 1'b0, 1'b1, 2'b11, 16'h1234, 16'h9999, 1'b0, 16'h0000);
        check_val("sel11", pc, 16'h4000);

        // wrap
        set_pc(16'hFFFF);
        step(1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check_val("wrap_pc", pc, 16'h0000);
        check_val("wrap_plus1", pc_plus1, 16'h0001);

        // forwarded address and in-flight address hold
        set_pc(16'h3010);
        step(1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check_val("fwd_addr", mem_addr, 16'h3011);
        step(1'b0, 1'b0, 1'b1, 2'b10, 16'h0000, 16'h5555, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check_val("hold_addr", mem_addr, 16'h3011);
        check_val("hold_pc", pc, 16'h5556);
        wait_edge(1'b1, 16'h7777);

        // reset in WAIT, stray ready afterwards
        fetch_start();
        wait_edge(1'b0, 16'h0000);
        wait_edge(1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'hBEEF);
        step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 16'hBEEF);
        check_val("abort_valid", 16'(instr_valid), 16'h0000);
        check_val("abort_rd", 16'(mem_rd), 16'h0000);
        check_val("abort_instr", instr, 16'h0000);
        check_val("abort_pc", pc, 16'h3000);

        // timeout / indefinite wait
        fetch_start();
        for (int i = 0; i < MW + 1; i++) wait_edge(1'b0, 16'h0000);
        if (TO_EN) begin
            check_val("to_instr", instr, 16'hF025);
            check_val("to_valid", 16'(instr_valid), 16'h0001);
            check_val("to_err", 16'(fetch_err), 16'h0001);
        end else begin
            check_val("nto_rd", 16'(mem_rd), 16'h0001);
            check_val("nto_err", 16'(fetch_err), 16'h0000);
            wait_edge(1'b1, 16'h0F0F);
        end

        // ready on the would-be timeout cycle wins
        fetch_start();
        for (int i = 0; i < MW; i++) wait_edge(1'b0, 16'h0000);
        wait_edge(1'b1, 16'hABCD);
        check_val("prio_instr", instr, 16'hABCD);
        check_val("prio_valid", 16'(instr_valid), 16'h0001);

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1),
                 2'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) == 0),
                 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
